prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Writable program store that replaces the fixed instruction ROM in front of the TD4 core.
- CPU side: same asynchronous read contract as the ROM. Address (PC) in, 8-bit Order (opcode[7:4], immediate[3:0]) out.
- Loader side: a valid/ready byte stream from a host. The block holds the CPU in clear while it wipes and reloads program memory, then releases the CPU to run from address 0.

Parameters:
- ADDR_W, 4, program address width. Depth = 2**ADDR_W words.
- DATA_W, 8, instruction word width.

Ports:
- CLK  input  1  system clock; all state changes on rising edge.
- CLR  input  1  asynchronous, active-low reset.
- START  input  1  single-cycle request to begin a load session. Sampled only in RUN.
- IN_VALID  input  1  host presents a program word.
- IN_DATA  input  DATA_W  program word. Written at the current write pointer.
- IN_LAST  input  1  qualifies IN_DATA as the final word of the session.
- IN_READY  output  1  loader accepts a word this cycle.
- Address  input  ADDR_W  CPU program counter.
- Order  output  DATA_W  instruction at Address. Combinational read.
- CPU_CLR  output  1  active-low clear to the CPU registers, PC and flag. Registered.
- BUSY  output  1  high in WIPE and LOAD.
- DONE  output  1  one-cycle pulse when a session ends.
- WORDS  output  ADDR_W+1  number of words written in the last completed session.

Behaviour:
- Reset (CLR low, asynchronous):
  - state=RUN; all memory words=0 (0x00 = ADD A,0, effectively a NOP).
  - write pointer wp=0; CPU_CLR=0 while CLR low; DONE=0; WORDS=0; IN_READY=0; BUSY=0.
  - First CLK edge after CLR deasserts: CPU_CLR registers to 1.
- States:
  - RUN: IN_READY=0; CPU_CLR=1. START=1 -> WIPE, wp=0, CPU_CLR goes 0 on the same edge.
  - WIPE: writes 0 to mem[wp] each cycle and increments wp. After writing word 2**ADDR_W-1 -> LOAD, wp=0. Takes exactly 2**ADDR_W cycles. IN_READY=0.
  - LOAD: IN_READY=1. On handshake (IN_VALID & IN_READY): mem[wp]=IN_DATA, wp++. Session ends when the handshake has IN_LAST=1 or wp==2**ADDR_W-1. At session end: -> RUN, DONE=1 for one cycle, WORDS=wp+1, CPU_CLR registers to 1 on that edge.
- CPU_CLR is low for every cycle in WIPE and LOAD. The CPU therefore restarts at PC=0 with A=B=OUT=0 and carry=0 on the first edge after release.
- Order = mem[Address] whenever state==RUN, otherwise forced to 0. No read latency, so the CPU timing is identical to the ROM.
- Write pointer wrap: it never wraps within a session. Reaching the top word ends the session even if IN_LAST=0.
- Words not written in a session stay 0 from WIPE, so no stale code survives.
- Boundary conditions:
  - START while BUSY: ignored.
  - START and IN_VALID together in RUN: only START acts; no write.
  - IN_VALID with IN_READY=0: no write, and the host holds the data.
  - IN_LAST on the first word: WORDS=1.
  - CLR mid-WIPE or mid-LOAD: immediate return to reset state; memory zeroed.
- All widths are unsigned. WORDS is one bit wider than ADDR_W so it can hold a full-depth count of 16.

Decomposition:
- Shared package:
  - state encoding typedef {RUN, WIPE, LOAD}.
  - constants DEPTH=2**ADDR_W and NOP_WORD=0.
  - opcode field constants [7:4] and [3:0], shared with the instruction decoder.
- One natural sub-module: prog_mem. It is a DEPTH x DATA_W flop array with async-low clear, one synchronous write port and one combinational read port.
- FSM, pointer and handshake logic live in prog_loader.

Test Plan:
- Reset: CLR low 3 cycles, Address swept 0..15 -> Order=0x00 everywhere; CPU_CLR=0 during reset, 1 one edge after CLR high; WORDS=0.
- Full load: START, then 16 words 0x30..0x3F with valid held, IN_LAST=0 -> IN_READY rises exactly 16 cycles after START; DONE once; WORDS=16; mem[i]=0x30+i; CPU_CLR low throughout, high with DONE.
- Short load with stale data: after the full load, START and then 3 words 0xB1,0x01,0xF0 with IN_LAST on the third -> WORDS=3; Address 3..15 reads 0x00; Order at Address 0 = 0xB1.
- Backpressure/ignored inputs: IN_VALID toggled randomly in LOAD -> writes only on handshake cycles. START pulsed during WIPE -> no restart; wipe still takes 16 cycles. IN_VALID during WIPE -> no write.
- Reset mid-load: CLR low after 5 words accepted -> all mem=0, state RUN, no DONE pulse, WORDS keeps reset value 0.
- CPU integration: load the LED blink program, release -> the CPU's OUT port sequence matches the ROM-based golden trace cycle for cycle, starting from PC=0.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared constants and state encoding for the writable TD4 program store.
// Opcode field positions are shared with the instruction decoder.
package prog_loader_pkg;

  localparam int PL_ADDR_W = 4;
  localparam int PL_DATA_W = 8;
  localparam int DEPTH     = 2 ** PL_ADDR_W;

  localparam logic [PL_DATA_W-1:0] NOP_WORD = '0;

  localparam int OP_HI  = 7;
  localparam int OP_LO  = 4;
  localparam int IMM_HI = 3;
  localparam int IMM_LO = 0;

  typedef logic [1:0] state_t;

  localparam state_t RUN  = 2'd0;
  localparam state_t WIPE = 2'd1;
  localparam state_t LOAD = 2'd2;

endpackage

// File: rtl/prog_mem.sv
// Flop-array program memory: async-low clear, one sync write port,
// one combinational read port.
module prog_mem #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          CLK,
  input  logic          CLR,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      for (int i = 0; i < 2**AW; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/prog_loader.sv
// Writable program store in front of the TD4 core: wipes, reloads from a
// valid/ready byte stream, and holds the CPU in clear while doing so.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = PL_ADDR_W,
  parameter int DATA_W = PL_DATA_W
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              START,
  input  logic              IN_VALID,
  input  logic [DATA_W-1:0] IN_DATA,
  input  logic              IN_LAST,
  output logic              IN_READY,
  input  logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] Order,
  output logic              CPU_CLR,
  output logic              BUSY,
  output logic              DONE,
  output logic [ADDR_W:0]   WORDS
);

  state_t            state;
  logic [ADDR_W-1:0] wp;
  logic              hs;
  logic              top;
  logic              we;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  assign IN_READY = (state == LOAD);
  assign BUSY     = (state != RUN);
  assign hs       = IN_VALID & IN_READY;
  assign top      = &wp;
  assign we       = (state == WIPE) | hs;
  assign wdata    = (state == WIPE) ? DATA_W'(NOP_WORD) : IN_DATA;
  assign Order    = (state == RUN) ? rdata : '0;

  prog_mem #(
    .AW(ADDR_W),
    .DW(DATA_W)
  ) u_mem (
    .CLK  (CLK),
    .CLR  (CLR),
    .we   (we),
    .waddr(wp),
    .wdata(wdata),
    .raddr(Address),
    .rdata(rdata)
  );

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state   <= RUN;
      wp      <= '0;
      CPU_CLR <= 1'b0;
      DONE    <= 1'b0;
      WORDS   <= '0;
    end else begin
      DONE <= 1'b0;
      unique case (1'b1)
        (state == RUN): begin
          if (START) begin
            state   <= WIPE;
            wp      <= '0;
            CPU_CLR <= 1'b0;
          end else begin
            CPU_CLR <= 1'b1;
          end
        end
        (state == WIPE): begin
          wp <= wp + 1'b1;
          if (top) begin
            state <= LOAD;
            wp    <= '0;
          end
        end
        (state == LOAD): begin
          if (hs) begin
            if (IN_LAST || top) begin
              state   <= RUN;
              wp      <= '0;
              DONE    <= 1'b1;
              CPU_CLR <= 1'b1;
              WORDS   <= {1'b0, wp} + (ADDR_W+1)'(1);
            end else begin
              wp <= wp + 1'b1;
            end
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed scoreboard bench for prog_loader, including a small
// behavioural TD4 subset that runs a loaded program.
module tb_prog_loader;

  logic       CLK = 1'b0;
  logic       CLR;
  logic       START;
  logic       IN_VALID;
  logic [7:0] IN_DATA;
  logic       IN_LAST;
  logic       IN_READY;
  logic [3:0] Address;
  logic [7:0] Order;
  logic       CPU_CLR;
  logic       BUSY;
  logic       DONE;
  logic [4:0] WORDS;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;

  logic [7:0] model [16];
  logic [7:0] prog  [16];
  logic [31:0] q [$];

  prog_loader dut (
    .CLK(CLK), .CLR(CLR), .START(START),
    .IN_VALID(IN_VALID), .IN_DATA(IN_DATA), .IN_LAST(IN_LAST),
    .IN_READY(IN_READY), .Address(Address), .Order(Order),
    .CPU_CLR(CPU_CLR), .BUSY(BUSY), .DONE(DONE), .WORDS(WORDS)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (DONE) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic readback(input string tag);
    for (int i = 0; i < 16; i++) q.push_back(32'(model[i]));
    for (int i = 0; i < 16; i++) begin
      Address = 4'(i);
      #1;
      chk(tag, 32'(Order), q.pop_front());
    end
  endtask

  task automatic start_session(input bit disturb);
    int cnt;
    Address  = 4'd0;
    START    = 1'b1;
    tick();
    START = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    chk("busy_after_start", 32'(BUSY), 32'd1);
    chk("cpu_clr_after_start", 32'(CPU_CLR), 32'd0);
    chk("order_forced_wipe", 32'(Order), 32'd0);
    cnt = 0;
    while (!IN_READY && cnt < 40) begin
      if (disturb && cnt == 3) begin
        START    = 1'b1;
        IN_VALID = 1'b1;
        IN_DATA  = 8'h55;
      end else begin
        START    = 1'b0;
        IN_VALID = 1'b0;
      end
      tick();
      cnt++;
      if (!IN_READY) chk("cpu_clr_wipe", 32'(CPU_CLR), 32'd0);
    end
    START    = 1'b0;
    IN_VALID = 1'b0;
    chk("wipe_cycles", 32'(cnt), 32'd16);
  endtask

  task automatic load(input int n, input bit last, input bit rnd,
                      input int stop_at);
    int acc;
    int guard;
    int d0;
    logic rdy;
    logic v;
    acc   = 0;
    guard = 0;
    d0    = done_cnt;
    while (acc < n && acc != stop_at && guard < 300) begin
      v        = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      IN_VALID = v;
      IN_DATA  = v ? prog[acc] : 8'hEE;
      IN_LAST  = last && (acc == n - 1);
      rdy      = IN_READY;
      tick();
      guard++;
      if (rdy && v) begin
        model[acc] = prog[acc];
        acc++;
      end
      if (acc < n && acc != stop_at)
        chk("cpu_clr_load", 32'(CPU_CLR), 32'd0);
    end
    IN_VALID = 1'b0;
    IN_LAST  = 1'b0;
    if (guard >= 300) chk("load_timeout", 32'(acc), 32'(n));
    if (acc == n) begin
      chk("done_pulse", 32'(DONE), 32'd1);
      chk("cpu_clr_release", 32'(CPU_CLR), 32'd1);
      chk("words", 32'(WORDS), 32'(n));
      chk("busy_end", 32'(BUSY), 32'd0);
      chk("ready_end", 32'(IN_READY), 32'd0);
      tick();
      chk("done_once", 32'(done_cnt - d0), 32'd1);
      chk("done_low", 32'(DONE), 32'd0);
    end
  endtask

  initial begin
    logic [7:0] instr;
    logic [3:0] pc;
    logic [3:0] outp;
    logic [3:0] a;
    int d0;

    CLR = 1'b0; START = 1'b0; IN_VALID = 1'b0;
    IN_DATA = 8'h00; IN_LAST = 1'b0; Address = 4'd0;
    for (int i = 0; i < 16; i++) model[i] = 8'h00;

    repeat (3) tick();
    chk("rst_cpu_clr", 32'(CPU_CLR), 32'd0);
    chk("rst_words", 32'(WORDS), 32'd0);
    chk("rst_ready", 32'(IN_READY), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    readback("rst_order");
    CLR = 1'b1;
    #1;
    chk("cpu_clr_before_edge", 32'(CPU_CLR), 32'd0);
    tick();
    chk("cpu_clr_after_rst", 32'(CPU_CLR), 32'd1);

    // Full-depth load ends on the top word with IN_LAST low
    for (int i = 0; i < 16; i++) prog[i] = 8'h30 + 8'(i);
    start_session(1'b0);
    load(16, 1'b0, 1'b0, -1);
    readback("full_order");

    // Short load over stale data, with disturbances during wipe
    prog[0] = 8'hB1; prog[1] = 8'h01; prog[2] = 8'hF0;
    start_session(1'b1);
    load(3, 1'b1, 1'b0, -1);
    readback("short_order");
    Address = 4'd0;
    #1;
    chk("short_addr0", 32'(Order), 32'hB1);

    // Backpressure: random valid, garbage data on idle cycles
    for (int i = 0; i < 16; i++) prog[i] = 8'(($urandom_range(1, 255)));
    start_session(1'b0);
    load(9, 1'b1, 1'b1, -1);
    readback("bp_order");

    // IN_LAST on the first word
    prog[0] = 8'h3A;
    start_session(1'b0);
    load(1, 1'b1, 1'b0, -1);
    readback("one_order");

    // Reset mid-load after five words
    CLR = 1'b0;
    tick();
    CLR = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) prog[i] = 8'h90 + 8'(i);
    start_session(1'b0);
    load(10, 1'b0, 1'b0, 5);
    d0 = done_cnt;
    CLR = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    chk("midrst_busy", 32'(BUSY), 32'd0);
    chk("midrst_ready", 32'(IN_READY), 32'd0);
    chk("midrst_cpu_clr", 32'(CPU_CLR), 32'd0);
    chk("midrst_words", 32'(WORDS), 32'd0);
    readback("midrst_order");
    tick();
    CLR = 1'b1;
    repeat (2) tick();
    chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    chk("midrst_cpu_run", 32'(CPU_CLR), 32'd1);

    // LED blink program driven through a tiny TD4 subset
    prog[0] = 8'hB3; prog[1] = 8'hB6; prog[2] = 8'hBC;
    prog[3] = 8'hB8; prog[4] = 8'hF0;
    start_session(1'b0);
    load(5, 1'b1, 1'b0, -1);
    pc = 4'd0; outp = 4'd0; a = 4'd0;
    q.delete();
    for (int r = 0; r < 3; r++) begin
      q.push_back(32'h3); q.push_back(32'h6); q.push_back(32'hC);
      q.push_back(32'h8); q.push_back(32'h8);
    end
    for (int c = 0; c < 15; c++) begin
      Address = pc;
      #1;
      instr = Order;
      tick();
      unique case (instr[7:4])
        4'hB: begin outp = instr[3:0]; pc = pc + 4'd1; end
        4'hF: pc = instr[3:0];
        4'h3: begin a = instr[3:0]; pc = pc + 4'd1; end
        4'h0: begin a = a + instr[3:0]; pc = pc + 4'd1; end
        default: pc = pc + 4'd1;
      endcase
      chk("cpu_out", 32'(outp), q.pop_front());
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
